// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte sources.
// A grant can be locked across a multi-byte message so messages never interleave.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           uart_data_o,
    output logic                 uart_send_o,
    input  logic                 uart_busy_i,
    output logic [IDX_W-1:0]     grant_id_o,
    output logic                 active_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StWaitDone,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             locked_q, locked_d;
    logic             send_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] sel;
    logic             xfer;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_found && req_valid_i[i] && (IDX_W'(i) >= ptr_q)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_found && req_valid_i[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    assign sel = (state_q == StHold) ? grant_q : win_idx;

    always_comb begin
        req_ready_o = '0;
        if (reset_n_i) begin
            if (state_q == StIdle && win_found && !uart_busy_i) begin
                req_ready_o[win_idx] = 1'b1;
            end else if (state_q == StHold) begin
                req_ready_o[grant_q] = 1'b1;
            end
        end
    end

    assign xfer = |(req_ready_o & req_valid_i);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        locked_d = locked_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (xfer) begin
                    data_d   = req_data_i[{sel, 3'b000} +: 8];
                    grant_d  = sel;
                    locked_d = !req_last_i[sel];
                    state_d  = StLaunch;
                end
            end
            StLaunch: state_d = StWaitStart;
            StWaitStart: begin
                if (uart_busy_i) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!uart_busy_i) begin
                    if (locked_q) begin
                        state_d = StHold;
                    end else begin
                        // Pointer only moves when a whole message is done.
                        state_d = StIdle;
                        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            data_q   <= 8'h00;
            locked_q <= 1'b0;
            send_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            locked_q <= locked_d;
            send_q   <= (state_d == StLaunch);
        end
    end

    assign uart_data_o = data_q;
    assign uart_send_o = send_q;
    assign grant_id_o  = grant_q;
    assign active_o    = (state_q != StIdle);

endmodule
